// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: picks one exception by priority and drives the
// CP0 commit bus plus the pipeline flush/redirect for a single cycle.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [31:0] mem_addr,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_trap,
  input  logic        exc_syscall,
  input  logic        exc_break,
  input  logic        exc_eret,
  input  logic        exc_adel_data,
  input  logic        exc_ades,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_data,
  output logic        mem_kill_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  // state  | meaning
  // IDLE   | watching MEM for exceptions; outputs held at zero
  // COMMIT | commit bus and flush valid for this one cycle
  typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;
  state_t state;

  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        int_pending, any_flag, accept;
  logic [31:0] sel_code, sel_bad;

  always_comb begin
    status_fwd = cp0_status;
    cause_fwd  = cp0_cause;
    epc_fwd    = cp0_epc;
    if (wb_cp0_we) begin
      if (wb_cp0_waddr == 5'd12) status_fwd = wb_cp0_data;
      // only the software-interrupt bits of cause are writable by mtc0
      if (wb_cp0_waddr == 5'd13) cause_fwd[9:8] = wb_cp0_data[9:8];
      if (wb_cp0_waddr == 5'd14) epc_fwd = wb_cp0_data;
    end
  end

  assign int_pending = status_fwd[0] & ~status_fwd[1] &
                       (|(cause_fwd[15:8] & status_fwd[15:8]));

  assign any_flag = exc_adel_if | exc_ri | exc_ov | exc_trap | exc_syscall |
                    exc_break | exc_eret | exc_adel_data | exc_ades;

  always_comb begin
    sel_code = 32'h0;
    sel_bad  = 32'h0;
    if (int_pending)        sel_code = 32'h1;
    else if (exc_adel_if)   begin sel_code = 32'h4; sel_bad = mem_pc;   end
    else if (exc_ri)        sel_code = 32'ha;
    else if (exc_ov)        sel_code = 32'hc;
    else if (exc_trap)      sel_code = 32'hd;
    else if (exc_syscall)   sel_code = 32'h8;
    else if (exc_break)     sel_code = 32'h9;
    else if (exc_adel_data) begin sel_code = 32'h4; sel_bad = mem_addr; end
    else if (exc_ades)      begin sel_code = 32'h5; sel_bad = mem_addr; end
    else if (exc_eret)      sel_code = 32'he;
  end

  assign accept     = (state == IDLE) & mem_valid & ~mem_stall & (int_pending | any_flag);
  assign mem_kill_o = accept & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            excepttype_o        <= sel_code;
            current_inst_addr_o <= mem_pc;
            is_in_delayslot_o   <= mem_in_delayslot;
            bad_addr_o          <= sel_bad;
            flush_o             <= 1'b1;
            new_pc_o            <= (sel_code == 32'he) ? epc_fwd : EXC_VECTOR;
            state               <= COMMIT;
          end
        end
        default: begin
          excepttype_o        <= 32'h0;
          current_inst_addr_o <= 32'h0;
          is_in_delayslot_o   <= 1'b0;
          bad_addr_o          <= 32'h0;
          flush_o             <= 1'b0;
          new_pc_o            <= 32'h0;
          state               <= IDLE;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl.
module tb_exception_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_stall, mem_in_delayslot;
  logic [31:0] mem_pc, mem_addr;
  logic        exc_adel_if, exc_ri, exc_ov, exc_trap, exc_syscall, exc_break;
  logic        exc_eret, exc_adel_data, exc_ades;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_waddr;
  logic [31:0] wb_cp0_data;
  logic        mem_kill_o, is_in_delayslot_o, flush_o;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;

  int checks = 0;
  int failures = 0;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot), .mem_addr(mem_addr),
    .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_trap(exc_trap),
    .exc_syscall(exc_syscall), .exc_break(exc_break), .exc_eret(exc_eret),
    .exc_adel_data(exc_adel_data), .exc_ades(exc_ades),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_data(wb_cp0_data),
    .mem_kill_o(mem_kill_o), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; mem_stall = 0; mem_in_delayslot = 0;
    mem_pc = 32'h0; mem_addr = 32'h0;
    exc_adel_if = 0; exc_ri = 0; exc_ov = 0; exc_trap = 0; exc_syscall = 0;
    exc_break = 0; exc_eret = 0; exc_adel_data = 0; exc_ades = 0;
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    wb_cp0_we = 0; wb_cp0_waddr = 5'd0; wb_cp0_data = 32'h0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_type"}, excepttype_o, 32'h0);
    check({tag, "_addr"}, current_inst_addr_o, 32'h0);
    check({tag, "_ds"}, {31'h0, is_in_delayslot_o}, 32'h0);
    check({tag, "_bad"}, bad_addr_o, 32'h0);
    check({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
    check({tag, "_newpc"}, new_pc_o, 32'h0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    // flags during reset must not kill
    mem_valid = 1; exc_syscall = 1;
    #12;
    check("rst_kill", {31'h0, mem_kill_o}, 32'h0);
    check_idle("rst");
    clear_inputs();
    @(negedge clk); rst = 0;
    tick();

    // syscall
    mem_valid = 1; mem_pc = 32'hBFC00100; exc_syscall = 1;
    #1 check("sys_kill", {31'h0, mem_kill_o}, 32'h1);
    tick();
    check("sys_type", excepttype_o, 32'h8);
    check("sys_addr", current_inst_addr_o, 32'hBFC00100);
    check("sys_ds", {31'h0, is_in_delayslot_o}, 32'h0);
    check("sys_bad", bad_addr_o, 32'h0);
    check("sys_flush", {31'h0, flush_o}, 32'h1);
    check("sys_newpc", new_pc_o, 32'hBFC00380);
    check("sys_commit_nokill", {31'h0, mem_kill_o}, 32'h0);
    clear_inputs();
    tick();
    check_idle("sys_t2");

    // interrupt beats RI
    mem_valid = 1; mem_pc = 32'h80000010; exc_ri = 1;
    cp0_status = 32'h00000401; cp0_cause = 32'h00000400;
    #1 check("int_kill", {31'h0, mem_kill_o}, 32'h1);
    tick();
    check("int_type", excepttype_o, 32'h1);
    check("int_newpc", new_pc_o, 32'hBFC00380);
    check("int_addr", current_inst_addr_o, 32'h80000010);
    clear_inputs();
    tick();

    // EXL set masks the interrupt, RI wins
    mem_valid = 1; mem_pc = 32'h80000010; exc_ri = 1;
    cp0_status = 32'h00000403; cp0_cause = 32'h00000400;
    tick();
    check("exl_type", excepttype_o, 32'ha);
    clear_inputs();
    tick();

    // store address error in a delay slot
    mem_valid = 1; mem_pc = 32'h80000020; mem_addr = 32'h00001003;
    mem_in_delayslot = 1; exc_ades = 1;
    tick();
    check("ades_type", excepttype_o, 32'h5);
    check("ades_bad", bad_addr_o, 32'h00001003);
    check("ades_ds", {31'h0, is_in_delayslot_o}, 32'h1);
    clear_inputs();
    tick();

    // adel_if outranks adel_data and reports the PC
    mem_valid = 1; mem_pc = 32'h80000031; mem_addr = 32'h00002001;
    exc_adel_if = 1; exc_adel_data = 1;
    tick();
    check("adelif_type", excepttype_o, 32'h4);
    check("adelif_bad", bad_addr_o, 32'h80000031);
    clear_inputs();
    tick();

    // load data address error reports the data address
    mem_valid = 1; mem_pc = 32'h80000040; mem_addr = 32'h00002002; exc_adel_data = 1;
    tick();
    check("adeld_type", excepttype_o, 32'h4);
    check("adeld_bad", bad_addr_o, 32'h00002002);
    clear_inputs();
    tick();

    // trap beats syscall; eret loses and is not performed
    mem_valid = 1; mem_pc = 32'h80000050; exc_trap = 1; exc_syscall = 1; exc_eret = 1;
    cp0_epc = 32'h00000100;
    tick();
    check("trap_type", excepttype_o, 32'hd);
    check("trap_newpc", new_pc_o, 32'hBFC00380);
    clear_inputs();
    tick();

    // eret with forwarded epc
    mem_valid = 1; mem_pc = 32'h80000060; exc_eret = 1; cp0_epc = 32'h00000100;
    wb_cp0_we = 1; wb_cp0_waddr = 5'd14; wb_cp0_data = 32'h00000200;
    tick();
    check("eret_type", excepttype_o, 32'he);
    check("eret_newpc", new_pc_o, 32'h00000200);
    check("eret_bad", bad_addr_o, 32'h0);
    clear_inputs();
    tick();

    // status forwarded from WB enables the interrupt
    mem_valid = 1; mem_pc = 32'h80000070; cp0_status = 32'h0; cp0_cause = 32'h00000400;
    wb_cp0_we = 1; wb_cp0_waddr = 5'd12; wb_cp0_data = 32'h00000401;
    #1 check("fwdst_kill", {31'h0, mem_kill_o}, 32'h1);
    tick();
    check("fwdst_type", excepttype_o, 32'h1);
    clear_inputs();
    tick();

    // cause[9:8] forwarded; other cause bits from WB data are ignored
    mem_valid = 1; mem_pc = 32'h80000080; cp0_status = 32'h00000101; cp0_cause = 32'h0;
    wb_cp0_we = 1; wb_cp0_waddr = 5'd13; wb_cp0_data = 32'h00000100;
    #1 check("fwdca_kill", {31'h0, mem_kill_o}, 32'h1);
    tick();
    check("fwdca_type", excepttype_o, 32'h1);
    clear_inputs();
    tick();
    mem_valid = 1; cp0_status = 32'h00000401; cp0_cause = 32'h0;
    wb_cp0_we = 1; wb_cp0_waddr = 5'd13; wb_cp0_data = 32'h00000400;
    #1 check("fwdca_mask_kill", {31'h0, mem_kill_o}, 32'h0);
    clear_inputs();
    tick();

    // bubble holds off a pending interrupt
    cp0_status = 32'h00000401; cp0_cause = 32'h00000400;
    #1 check("bubble_kill", {31'h0, mem_kill_o}, 32'h0);
    tick();
    check("bubble_flush", {31'h0, flush_o}, 32'h0);
    clear_inputs();

    // overflow under a 3-cycle stall
    mem_valid = 1; mem_pc = 32'h80000090; exc_ov = 1; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_kill", {31'h0, mem_kill_o}, 32'h0);
      tick();
      check("stall_flush", {31'h0, flush_o}, 32'h0);
    end
    mem_stall = 0;
    #1 check("unstall_kill", {31'h0, mem_kill_o}, 32'h1);
    tick();
    check("ov_type", excepttype_o, 32'hc);
    check("ov_flush", {31'h0, flush_o}, 32'h1);
    clear_inputs();
    tick();

    // async reset during COMMIT
    mem_valid = 1; mem_pc = 32'h800000a0; exc_break = 1;
    tick();
    check("brk_type", excepttype_o, 32'h9);
    clear_inputs();
    #2 rst = 1;
    #1;
    check("rstc_flush", {31'h0, flush_o}, 32'h0);
    check("rstc_type", excepttype_o, 32'h0);
    @(negedge clk); rst = 0;
    tick();
    check_idle("post_rst");
    // still IDLE: a new exception is accepted immediately
    mem_valid = 1; exc_syscall = 1; mem_pc = 32'h800000b0;
    #1 check("post_rst_kill", {31'h0, mem_kill_o}, 32'h1);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
